// File: rtl/dcpu16_pkg.sv
//------------------------------------------------------------------------------
// Module   : dcpu16_pkg
// Purpose  : Shared types and helpers for the DCPU16 memory bus arbiter:
//            arbiter state encoding and a ceil-log2 helper for index widths.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package dcpu16_pkg;

  // Arbiter states, 2-bit encoding
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_ACK  = 2'd2
  } mbus_state_e;

  // Ceil(log2(n)); returns 0 for n <= 1
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/dcpu16_mbus_pick.sv
//------------------------------------------------------------------------------
// Module   : dcpu16_mbus_pick
// Purpose  : Combinational rotating-priority picker. Scans req_i starting at
//            start_i (wrapping modulo NCH) and reports the first set index.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module dcpu16_mbus_pick #(
  parameter int NCH = 2,
  parameter int IW  = 1
) (
  input  logic [NCH-1:0] req_i,
  input  logic [IW-1:0]  start_i,
  output logic [IW-1:0]  gnt_o,
  output logic           any_o
);

  logic [IW-1:0] w_idx;
  logic          w_found;

  // First requester at or after start_i, wrapping around the channel count
  always_comb begin
    w_idx   = '0;
    w_found = 1'b0;
    gnt_o   = '0;
    for (int i = 0; i < NCH; i++) begin
      w_idx = IW'((int'(start_i) + i) % NCH);
      if (!w_found && req_i[w_idx]) begin
        w_found = 1'b1;
        gnt_o   = w_idx;
      end
    end
    any_o = w_found;
  end

endmodule

`default_nettype wire

// File: rtl/dcpu16_mbus_arb.sv
//------------------------------------------------------------------------------
// Module   : dcpu16_mbus_arb
// Purpose  : N-channel stb/wre/ack memory bus arbiter for the DCPU16 core.
//            Merges F-bus, A-bus and optional DMA masters onto one memory
//            port. All outputs are registered.
// Config   : DCPU16_MBUS_RR_EN defined   -> round-robin arbitration
//            DCPU16_MBUS_RR_EN undefined -> fixed priority, lowest index wins
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module dcpu16_mbus_arb
  import dcpu16_pkg::*;
#(
  parameter int NCH = 2,
  parameter int AW  = 16,
  parameter int DW  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NCH*AW-1:0] ch_adr,
  input  logic [NCH*DW-1:0] ch_dto,
  input  logic [NCH-1:0]    ch_stb,
  input  logic [NCH-1:0]    ch_wre,
  output logic [DW-1:0]     ch_dti,
  output logic [NCH-1:0]    ch_ack,
  output logic [AW-1:0]     mb_adr,
  output logic [DW-1:0]     mb_dto,
  output logic              mb_stb,
  output logic              mb_wre,
  input  logic [DW-1:0]     mb_dti,
  input  logic              mb_ack
);

  localparam int IW = (NCH > 1) ? clog2(NCH) : 1;

  mbus_state_e    state_q, state_d;
  logic [IW-1:0]  gnt_q, gnt_d;
  logic [AW-1:0]  mb_adr_q, mb_adr_d;
  logic [DW-1:0]  mb_dto_q, mb_dto_d;
  logic           mb_stb_q, mb_stb_d;
  logic           mb_wre_q, mb_wre_d;
  logic [NCH-1:0] ch_ack_q, ch_ack_d;
  logic [DW-1:0]  ch_dti_q, ch_dti_d;

  logic [IW-1:0]  w_start;
  logic [IW-1:0]  w_pick;
  logic           w_any;
  logic [AW-1:0]  w_adr [NCH];
  logic [DW-1:0]  w_dto [NCH];

  // Split the flat channel buses into per-channel words
  for (genvar gi = 0; gi < NCH; gi++) begin : g_unpack
    assign w_adr[gi] = ch_adr[gi*AW +: AW];
    assign w_dto[gi] = ch_dto[gi*DW +: DW];
  end

`ifdef DCPU16_MBUS_RR_EN
  localparam logic [IW-1:0] LAST = IW'(NCH - 1);

  logic [IW-1:0] ptr_q, ptr_d;

  // Search begins one past the last winner so every channel gets a turn
  assign w_start = (ptr_q == LAST) ? '0 : ptr_q + 1'b1;

  // Remember the most recent winner; reset value makes channel 0 win first
  always_ff @(posedge clk) begin
    if (rst) ptr_q <= LAST;
    else     ptr_q <= ptr_d;
  end

  // Pointer follows every grant
  always_comb begin
    ptr_d = ptr_q;
    if (state_q == ST_IDLE && w_any) ptr_d = w_pick;
  end
`else
  // Fixed priority: always scan from channel 0
  assign w_start = '0;
`endif

  dcpu16_mbus_pick #(
    .NCH (NCH),
    .IW  (IW)
  ) u_pick (
    .req_i   (ch_stb),
    .start_i (w_start),
    .gnt_o   (w_pick),
    .any_o   (w_any)
  );

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      gnt_q    <= '0;
      mb_adr_q <= '0;
      mb_dto_q <= '0;
      mb_stb_q <= 1'b0;
      mb_wre_q <= 1'b0;
      ch_ack_q <= '0;
      ch_dti_q <= '0;
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      mb_adr_q <= mb_adr_d;
      mb_dto_q <= mb_dto_d;
      mb_stb_q <= mb_stb_d;
      mb_wre_q <= mb_wre_d;
      ch_ack_q <= ch_ack_d;
      ch_dti_q <= ch_dti_d;
    end
  end

  // Grant in IDLE, wait for memory in REQ, single-cycle ack in ACK
  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    mb_adr_d = mb_adr_q;
    mb_dto_d = mb_dto_q;
    mb_stb_d = mb_stb_q;
    mb_wre_d = mb_wre_q;
    ch_ack_d = '0;
    ch_dti_d = ch_dti_q;
    case (state_q)
      ST_IDLE: begin
        if (w_any) begin
          gnt_d    = w_pick;
          mb_adr_d = w_adr[w_pick];
          mb_dto_d = w_dto[w_pick];
          mb_wre_d = ch_wre[w_pick];
          mb_stb_d = 1'b1;
          state_d  = ST_REQ;
        end else begin
          mb_stb_d = 1'b0;
        end
      end
      ST_REQ: begin
        // Completes even if the master has dropped its strobe meanwhile
        if (mb_ack) begin
          ch_dti_d        = mb_dti;
          mb_stb_d        = 1'b0;
          ch_ack_d[gnt_q] = 1'b1;
          state_d         = ST_ACK;
        end
      end
      ST_ACK: begin
        // Served master still drives stb here, so no arbitration this cycle
        state_d = ST_IDLE;
      end
      default: begin
        state_d  = ST_IDLE;
        mb_stb_d = 1'b0;
      end
    endcase
  end

  assign mb_adr = mb_adr_q;
  assign mb_dto = mb_dto_q;
  assign mb_stb = mb_stb_q;
  assign mb_wre = mb_wre_q;
  assign ch_ack = ch_ack_q;
  assign ch_dti = ch_dti_q;

endmodule

`default_nettype wire

// File: tb/tb_dcpu16_mbus_arb.sv
//------------------------------------------------------------------------------
// Module   : tb_dcpu16_mbus_arb
// Purpose  : Self-checking bench for dcpu16_mbus_arb (NCH=4). A transaction
//            level reference model predicts grants and acks into queues; a
//            monitor compares them as the DUT presents them.
//            Honours DCPU16_MBUS_RR_EN for the expected arbitration order.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_dcpu16_mbus_arb;

  localparam int NCH = 4;
  localparam int AW  = 16;
  localparam int DW  = 16;

  logic              clk;
  logic              rst;
  logic [NCH*AW-1:0] ch_adr;
  logic [NCH*DW-1:0] ch_dto;
  logic [NCH-1:0]    ch_stb;
  logic [NCH-1:0]    ch_wre;
  logic [DW-1:0]     ch_dti;
  logic [NCH-1:0]    ch_ack;
  logic [AW-1:0]     mb_adr;
  logic [DW-1:0]     mb_dto;
  logic              mb_stb;
  logic              mb_wre;
  logic [DW-1:0]     mb_dti;
  logic              mb_ack;

  dcpu16_mbus_arb #(.NCH(NCH), .AW(AW), .DW(DW)) dut (
    .clk    (clk),
    .rst    (rst),
    .ch_adr (ch_adr),
    .ch_dto (ch_dto),
    .ch_stb (ch_stb),
    .ch_wre (ch_wre),
    .ch_dti (ch_dti),
    .ch_ack (ch_ack),
    .mb_adr (mb_adr),
    .mb_dto (mb_dto),
    .mb_stb (mb_stb),
    .mb_wre (mb_wre),
    .mb_dti (mb_dti),
    .mb_ack (mb_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- bookkeeping ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic fail(input string name);
    n_checks++;
    $display("FAIL %s: got timeout, expected completion", name);
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    int            ch;
    logic [AW-1:0] adr;
    logic          wre;
    logic [DW-1:0] dto;
  } grant_t;

  typedef struct {
    int            ch;
    logic [DW-1:0] dti;
  } ack_t;

  grant_t gq[$];
  ack_t   aq[$];
  int     cyc = 0;
  bit     m_owned = 0;
  int     m_owner = 0;
  int     m_free_at = 0;
  int     m_ptr = NCH - 1;

  // Who should win among the set requesters, given the last winner
  function automatic int pick(input logic [NCH-1:0] req, input int last);
`ifdef DCPU16_MBUS_RR_EN
    for (int k = 1; k <= NCH; k++)
      if (req[(last + k) % NCH]) return (last + k) % NCH;
`else
    for (int k = 0; k < NCH; k++)
      if (req[k]) return k;
`endif
    return -1;
  endfunction

  // Bus is owned from grant to memory completion; it may be granted again
  // two cycles after the memory completion.
  always @(posedge clk) begin
    grant_t g;
    int     w;
    cyc++;
    if (rst) begin
      gq.delete();
      aq.delete();
      m_owned   = 0;
      m_free_at = 0;
      m_ptr     = NCH - 1;
    end else if (m_owned) begin
      if (mb_ack) begin
        aq.push_back('{ch: m_owner, dti: mb_dti});
        m_owned   = 0;
        m_free_at = cyc + 2;
      end
    end else if (cyc >= m_free_at && ch_stb != '0) begin
      w     = pick(ch_stb, m_ptr);
      g.ch  = w;
      g.adr = ch_adr[w*AW +: AW];
      g.wre = ch_wre[w];
      g.dto = ch_dto[w*DW +: DW];
      gq.push_back(g);
      m_owned = 1;
      m_owner = w;
      m_ptr   = w;
    end
  end

  // ---------------- memory model ----------------
  logic [DW-1:0] mem [int];
  int force_wait = -1;
  int wcnt = -1;

  initial begin
    mb_ack = 1'b0;
    mb_dti = '0;
    forever begin
      @(posedge clk);
      #1;
      mb_ack = 1'b0;
      if (mb_stb && !rst) begin
        if (wcnt < 0) wcnt = (force_wait >= 0) ? force_wait : int'($urandom_range(0, 3));
        if (wcnt == 0) begin
          mb_ack = 1'b1;
          if (mb_wre) begin
            mem[int'(mb_adr)] = mb_dto;
            mb_dti = DW'($urandom);
          end else begin
            mb_dti = mem.exists(int'(mb_adr)) ? mem[int'(mb_adr)] : '0;
          end
          wcnt = -1;
        end else begin
          wcnt--;
        end
      end else begin
        wcnt = -1;
      end
    end
  end

  // ---------------- monitor ----------------
  logic [NCH-1:0] ack_log[$];
  int             ack_cyc[$];
  bit             prev_stb = 0;
  grant_t         mon_g;
  ack_t           mon_a;

  always @(negedge clk) begin
    if (rst) begin
      prev_stb = 0;
    end else begin
      if (mb_stb && !prev_stb) begin
        if (gq.size() == 0) begin
          n_checks++;
          $display("FAIL grant: got unexpected mb_stb adr %0h, expected none", mb_adr);
        end else begin
          mon_g = gq.pop_front();
          chk("grant mb_adr", 32'(mb_adr), 32'(mon_g.adr));
          chk("grant mb_wre", 32'(mb_wre), 32'(mon_g.wre));
          if (mon_g.wre) chk("grant mb_dto", 32'(mb_dto), 32'(mon_g.dto));
        end
      end else if (mb_stb) begin
        chk("mb_adr stable", 32'(mb_adr), 32'(mon_g.adr));
      end
      if (ch_ack != '0) begin
        ack_log.push_back(ch_ack);
        ack_cyc.push_back(cyc);
        if (aq.size() == 0) begin
          n_checks++;
          $display("FAIL ack: got unexpected ch_ack %0h, expected none", ch_ack);
        end else begin
          mon_a = aq.pop_front();
          chk("ch_ack onehot", 32'(ch_ack), 32'(1) << mon_a.ch);
          chk("ch_dti", 32'(ch_dti), 32'(mon_a.dti));
        end
      end
      prev_stb = mb_stb;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic req(input int c, input logic [AW-1:0] adr, input logic wre,
                     input logic [DW-1:0] dto, input bit drop, output int lat);
    @(posedge clk);
    #1;
    ch_adr[c*AW +: AW] = adr;
    ch_dto[c*DW +: DW] = dto;
    ch_wre[c]          = wre;
    ch_stb[c]          = 1'b1;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (drop && mb_stb) ch_stb[c] = 1'b0;
    end while (!ch_ack[c] && lat < 400);
    if (!ch_ack[c]) fail($sformatf("ack timeout ch%0d", c));
    @(posedge clk);
    #1;
    ch_stb[c] = 1'b0;
  endtask

  int n_done = 0;

  task automatic run_master(input int c, input int n);
    int lat;
    for (int t = 0; t < n; t++) begin
      repeat ($urandom_range(0, 6)) @(posedge clk);
      req(c, AW'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), DW'($urandom), 0, lat);
    end
    n_done++;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int lat;
    int guard;
    rst    = 1'b1;
    ch_adr = '0;
    ch_dto = '0;
    ch_stb = '0;
    ch_wre = '0;
    mem[16'h1234] = 16'hBEEF;
    repeat (3) @(negedge clk);

    // Reset values
    chk("reset mb_stb", 32'(mb_stb), 0);
    chk("reset mb_wre", 32'(mb_wre), 0);
    chk("reset mb_adr", 32'(mb_adr), 0);
    chk("reset mb_dto", 32'(mb_dto), 0);
    chk("reset ch_ack", 32'(ch_ack), 0);
    chk("reset ch_dti", 32'(ch_dti), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Contention: all channels hold stb, zero-wait memory
    force_wait = 0;
    ack_log.delete();
    ack_cyc.delete();
    @(posedge clk);
    #1;
    for (int c = 0; c < NCH; c++) ch_adr[c*AW +: AW] = AW'(16'h0100 + c);
    ch_wre = '0;
    ch_stb = '1;
    guard  = 0;
    while (ack_log.size() < 5 && guard < 100) begin
      @(posedge clk);
      #1;
      guard++;
    end
    ch_stb = '0;
    if (ack_log.size() < 5) fail("contention acks");
    else begin
`ifdef DCPU16_MBUS_RR_EN
      chk("contention order 0", 32'(ack_log[0]), 1);
      chk("contention order 1", 32'(ack_log[1]), 2);
      chk("contention order 2", 32'(ack_log[2]), 4);
      chk("contention order 3", 32'(ack_log[3]), 8);
      chk("contention order 4", 32'(ack_log[4]), 1);
`else
      for (int i = 0; i < 5; i++) chk($sformatf("contention order %0d", i), 32'(ack_log[i]), 1);
`endif
      for (int i = 1; i < 5; i++) chk("contention ack spacing", 32'(ack_cyc[i] - ack_cyc[i-1]), 3);
    end
    repeat (3) @(posedge clk);

    // Single read with two wait states
    force_wait = 2;
    req(0, 16'h1234, 1'b0, '0, 0, lat);
    chk("read latency", 32'(lat - 1), 4);
    chk("read ch_dti", 32'(ch_dti), 32'h0000BEEF);

    // Write pass-through on channel 1, zero-wait, then read back
    force_wait = 0;
    req(1, 16'h0010, 1'b1, 16'hA5A5, 0, lat);
    chk("write latency", 32'(lat - 1), 2);
    req(0, 16'h0010, 1'b0, '0, 0, lat);
    chk("readback ch_dti", 32'(ch_dti), 32'h0000A5A5);

    // Dropped strobe: cycle still completes with exactly one ack
    force_wait = 2;
    ack_log.delete();
    req(0, 16'h0042, 1'b0, '0, 1, lat);
    repeat (4) @(negedge clk);
    chk("dropped stb ack count", 32'(ack_log.size()), 1);

    // Randomized traffic from all masters concurrently
    force_wait = -1;
    for (int c = 0; c < NCH; c++) begin
      fork
        automatic int cc = c;
        run_master(cc, 10);
      join_none
    end
    guard = 0;
    while (n_done < NCH && guard < 20000) begin
      @(posedge clk);
      guard++;
    end
    if (n_done < NCH) fail("random phase");
    repeat (5) @(posedge clk);

    // Reset in the same cycle as mb_ack
    force_wait = 0;
    req(0, 16'h1234, 1'b0, '0, 0, lat);
    force_wait = 1;
    @(posedge clk);
    #1;
    ch_adr[0 +: AW] = 16'h0003;
    ch_wre[0]       = 1'b0;
    ch_stb[0]       = 1'b1;
    guard = 0;
    do begin
      @(negedge clk);
      guard++;
    end while (!mb_ack && guard < 50);
    if (!mb_ack) fail("mb_ack before reset");
    rst       = 1'b1;
    ch_stb[0] = 1'b0;
    @(posedge clk);
    #1;
    chk("reset-in-REQ mb_stb", 32'(mb_stb), 0);
    chk("reset-in-REQ ch_ack", 32'(ch_ack), 0);
    chk("reset-in-REQ ch_dti", 32'(ch_dti), 0);
    rst = 1'b0;
    ack_log.delete();
    repeat (4) @(negedge clk);
    chk("no ack after reset", 32'(ack_log.size()), 0);

    // Recovery after reset
    force_wait = 0;
    req(2, 16'h1234, 1'b0, '0, 0, lat);
    chk("post-reset read ch_dti", 32'(ch_dti), 32'h0000BEEF);
    repeat (4) @(negedge clk);
    chk("queues drained", 32'(gq.size() + aq.size()), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Global watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: got simulation time limit, expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
